// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALUOp values (also consumed by ALU_CONTROL) and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADR,
    S_MEM_RD,
    S_LD_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_UPPER,
    S_ILLEGAL,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_ADD    = 3'b010;
  localparam logic [2:0] ALUOP_IALU   = 3'b011;
  localparam logic [2:0] ALUOP_UPPER  = 3'b100;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/branch_cond.sv
// Branch decision from funct3 and the ALU compare flags; purely combinational.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = alu_zero;
      3'b001:         taken = !alu_zero;
      3'b100, 3'b110: taken = alu_lt;
      3'b101, 3'b111: taken = !alu_lt;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main control FSM around a single shared ALU and one memory port.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes pulse illegal_instr and park in HALT.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] result_src,
  output logic       reg_write,
  output logic       mem_err,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic       instr_done
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             fresh;      // first cycle after reset: FETCH without a request
  logic             is_store;
  logic             is_auipc;
  logic             timeout;
  logic             at_limit;
  logic             taken;

  branch_cond u_branch_cond (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .taken    (taken)
  );

  assign at_limit = !fresh && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state    <= S_FETCH;
      fresh    <= 1'b1;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
      is_store <= 1'b0;
      is_auipc <= 1'b0;
    end else begin
      state <= state_n;
      fresh <= 1'b0;
      if (timeout) mem_err <= 1'b1;
      // Wait counter restarts on every state entry, including a timeout retry.
      if ((state_n != state) || timeout) wait_cnt <= '0;
      else if (mem_req && !mem_ready)    wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == S_DECODE) begin
        is_store <= (opcode == OP_STORE);
        is_auipc <= (opcode == OP_AUIPC);
      end
    end
  end

  always_comb begin
    state_n    = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALUOP_R;
    result_src = RES_ALUOUT;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    timeout    = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        alu_src_b = SRC_B_FOUR;
        if (at_limit) begin
          timeout = 1'b1;
        end else if (!fresh) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_n  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_R:              state_n = S_EXEC_R;
          OP_IMM:            state_n = S_EXEC_I;
          OP_LOAD, OP_STORE: state_n = S_MEM_ADR;
          OP_BRANCH:         state_n = S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          OP_JALR:           state_n = S_JALR;
          OP_LUI, OP_AUIPC:  state_n = S_UPPER;
          default:           state_n = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALUOP_R;
        state_n   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_IALU;
        state_n   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_ADD;
        state_n   = is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        adr_src = 1'b1;
        if (at_limit) begin
          timeout = 1'b1;
          state_n = S_FETCH;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) state_n = S_LD_WB;
        end
      end
      S_LD_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEM_WR: begin
        adr_src = 1'b1;
        if (at_limit) begin
          timeout = 1'b1;
          state_n = S_FETCH;
        end else begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_n    = S_FETCH;
          end
        end
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALUOP_BRANCH;
        pc_write   = taken;
        result_src = RES_ALUOUT;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_ALU;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b1;
        result_src = RES_ALU;
        state_n    = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b1;
        result_src = RES_ALU;
        instr_done = 1'b1;
        state_n    = S_FETCH;
      end
      S_UPPER: begin
        // LUI relies on the datapath forcing rs1 to x0.
        alu_src_a = is_auipc ? SRC_A_PC : SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_UPPER;
        state_n   = S_ALU_WB;
      end
      S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_instr = 1'b1;
        state_n       = S_HALT;
`else
        instr_done = 1'b1;
        state_n    = S_FETCH;
`endif
      end
      S_HALT: state_n = S_HALT;
    endcase
  end

endmodule
